weight_loader: RTL and testbench

//  Write-side controller for the per-column weight FIFO array. It accepts 32-bit AXI-stream weight beats.
//  It steers each beat into one column FIFO through a one-hot fifo_en, filling columns in order, col 0 first.

---
 rtl/cnn_pkg.sv | 13 +
 rtl/weight_skew_gen.sv | 45 ++++
 rtl/weight_loader.sv | 146 ++++++++++++++
 tb/tb_weight_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN weight path.
package cnn_pkg;

    localparam int unsigned AXI_W = 32;

    typedef enum logic [1:0] {
        WL_IDLE,
        WL_LOAD,
        WL_STREAM,
        WL_DONE
    } wl_state_t;

endpackage

// File: rtl/weight_skew_gen.sv
// Stream-phase timer: owns t and the diagonally skewed per-column read enables.
module weight_skew_gen #(
    parameter int unsigned col   = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       go,
    input  logic [$clog2(DEPTH+1)-1:0] nw,
    output logic [col-1:0]             out_en,
    output logic                       last
);

    localparam int unsigned TW = $clog2(col + 2 * DEPTH);

    logic [TW-1:0] t;
    logic [31:0]   t_ext;
    logic [31:0]   span;

    assign t_ext = 32'(t);
    assign span  = 32'(nw) << 1;

    // t sits at 0 until go rises, so the first streaming cycle sees t == 0
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            t <= '0;
        end else if (go) begin
            t <= t + TW'(1);
        end else begin
            t <= '0;
        end
    end

    always_comb begin
        out_en = '0;
        last   = 1'b0;
        if (go) begin
            for (int unsigned i = 0; i < col; i++) begin
                out_en[i] = (t_ext >= i) && (t_ext < i + span);
            end
            last = (t_ext == col - 1 + span - 1);
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Write-side controller for the column weight FIFOs: loads AXI-stream beats column by column,
// then replays with skewed read enables. Define WL_LAST_CHECK_EN to enable s_last framing checks.
module weight_loader
    import cnn_pkg::*;
#(
    parameter int unsigned col        = 32,
    parameter int unsigned data_width = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] num_words,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [AXI_W-1:0]           s_data,
    input  logic                       s_last,
    output logic [AXI_W-1:0]           weight_in,
    output logic [col-1:0]             fifo_en,
    output logic [col-1:0]             out_en,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned NWW = $clog2(DEPTH + 1);
    localparam int unsigned WCW = $clog2(DEPTH);
    localparam int unsigned CIW = $clog2(col);

    wl_state_t      state, state_nx;
    logic [NWW-1:0] nw, nw_clamped;
    logic [WCW-1:0] word_cnt;
    logic [CIW-1:0] col_idx;
    logic           start_ok, beat, last_word, last_col, streaming, stream_last;

    // each beat carries two data_width weights; the split happens in the FIFO array
    logic [data_width-1:0] unused_lo_weight;
    assign unused_lo_weight = weight_in[data_width-1:0];

    assign nw_clamped = (num_words > NWW'(DEPTH)) ? NWW'(DEPTH) : num_words;
    assign start_ok   = (state == WL_IDLE) && start;
    assign s_ready    = (state == WL_LOAD);
    assign beat       = s_valid && s_ready;
    assign last_word  = (32'(word_cnt) == 32'(nw) - 1);
    assign last_col   = (32'(col_idx) == col - 1);
    assign streaming  = (state == WL_STREAM);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= WL_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            WL_IDLE: begin
                if (start) begin
                    state_nx = (nw_clamped == '0) ? WL_DONE : WL_LOAD;
                end
            end
            WL_LOAD: begin
                busy = 1'b1;
                if (beat && last_word && last_col) begin
                    state_nx = WL_STREAM;
                end
            end
            WL_STREAM: begin
                busy = 1'b1;
                if (stream_last) begin
                    state_nx = WL_DONE;
                end
            end
            WL_DONE: begin
                done     = 1'b1;
                state_nx = WL_IDLE;
            end
            default: state_nx = WL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nw       <= '0;
            word_cnt <= '0;
            col_idx  <= '0;
        end else if (start_ok) begin
            nw       <= nw_clamped;
            word_cnt <= '0;
            col_idx  <= '0;
        end else if (beat) begin
            if (last_word) begin
                word_cnt <= '0;
                col_idx  <= col_idx + CIW'(1);
            end else begin
                word_cnt <= word_cnt + WCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fifo_en   <= '0;
            weight_in <= '0;
        end else begin
            fifo_en <= '0;
            if (beat) begin
                fifo_en[col_idx] <= 1'b1;
                weight_in        <= s_data;
            end
        end
    end

`ifdef WL_LAST_CHECK_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (beat && (s_last != (last_word && last_col))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign err         = 1'b0;
`endif

    weight_skew_gen #(
        .col   (col),
        .DEPTH (DEPTH)
    ) u_skew (
        .clk    (clk),
        .nrst   (nrst),
        .go     (streaming),
        .nw     (nw),
        .out_en (out_en),
        .last   (stream_last)
    );

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader (col=4, DEPTH=16): table-driven jobs, random jobs, reset abort.
module tb_weight_loader;

    localparam int COL   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [4:0]  num_words;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [31:0] weight_in;
    logic [COL-1:0] fifo_en;
    logic [COL-1:0] out_en;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] last_w;
    logic        err_exp;

    typedef struct {
        int nwq;
        int mode;        // 0: valid held, 1: toggled, 2: random, 3: held + stray starts
        int bad_last;    // beat index carrying a spurious s_last, -1 for none
        int exp_beats;
        int exp_stream;
    } job_t;

    job_t tbl[8];

    weight_loader #(
        .col        (COL),
        .data_width (16),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .weight_in (weight_in),
        .fifo_en   (fifo_en),
        .out_en    (out_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_job(input int nwq, input int mode, input int bad_last,
                          input int exp_beats, input int exp_stream);
        int nw, total, idx, pending, guard, beats_seen, stream_seen;
        logic [31:0] data_q[$];
        logic [COL-1:0] m;
        logic v, bad_flag;
        nw = (nwq > DEPTH) ? DEPTH : nwq;
        total = COL * nw;
        idx = 0; pending = -1; guard = 0; beats_seen = 0; stream_seen = 0;
        start = 1'b1; num_words = 5'(nwq); s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        start = 1'b0;
`ifdef WL_LAST_CHECK_EN
        err_exp = 1'b0;
`endif
        if (nw == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_ready", s_ready, 0);
            chk("zero_fifo_en", fifo_en, 0);
            chk("zero_out_en", out_en, 0);
            chk("zero_err", err, err_exp);
            @(negedge clk);
            chk("zero_done_drop", done, 0);
            chk("zero_ready2", s_ready, 0);
            chk("zero_out_en2", out_en, 0);
            return;
        end
        while (idx < total && guard < 2000) begin
            chk("load_busy", busy, 1);
            chk("load_ready", s_ready, 1);
            chk("load_done", done, 0);
            chk("load_out_en", out_en, 0);
            chk("load_err", err, err_exp);
            if (fifo_en != 0) beats_seen++;
            if (pending >= 0) begin
                chk("load_fifo_en", fifo_en, 64'(1) << (pending / nw));
                chk("load_weight", weight_in, data_q[pending]);
            end else begin
                chk("stall_fifo_en", fifo_en, 0);
                chk("stall_weight", weight_in, last_w);
            end
            case (mode)
                1: v = (guard % 2 == 0);
                2: v = 1'($urandom % 2);
                default: v = 1'b1;
            endcase
            start = (mode == 3) && ($urandom % 2 == 1);
            num_words = 5'd0;
            bad_flag = 1'b0;
            if (v) begin
                s_data = $urandom;
                s_valid = 1'b1;
                data_q.push_back(s_data);
                s_last = (bad_last >= 0) ? (idx == bad_last) : (idx == total - 1);
                bad_flag = (s_last != (idx == total - 1));
                last_w = s_data;
                pending = idx;
                idx++;
            end else begin
                s_valid = 1'b0;
                s_data = $urandom;
                s_last = 1'($urandom % 2);
                pending = -1;
            end
            @(negedge clk);
            guard++;
`ifdef WL_LAST_CHECK_EN
            if (bad_flag) err_exp = 1'b1;
`endif
        end
        chk("load_timeout", idx, total);
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        for (int t = 0; t < COL - 1 + 2 * nw; t++) begin
            chk("stream_busy", busy, 1);
            chk("stream_ready", s_ready, 0);
            chk("stream_done", done, 0);
            chk("stream_err", err, err_exp);
            for (int i = 0; i < COL; i++) m[i] = (t >= i) && (t < i + 2 * nw);
            chk("stream_out_en", out_en, m);
            if (out_en != 0) stream_seen++;
            if (fifo_en != 0) beats_seen++;
            if (t == 0 && pending >= 0) begin
                chk("last_fifo_en", fifo_en, 64'(1) << (pending / nw));
                chk("last_weight", weight_in, data_q[pending]);
            end else begin
                chk("stream_fifo_en", fifo_en, 0);
                chk("stream_weight", weight_in, last_w);
            end
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_out_en", out_en, 0);
        chk("done_err", err, err_exp);
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("idle_ready", s_ready, 0);
        chk("job_beats", beats_seen, exp_beats);
        chk("job_stream_cycles", stream_seen, exp_stream);
    endtask

    initial begin
        int nwq, nwc;
        tbl[0] = '{2,  0, -1,  8,  7};
        tbl[1] = '{2,  1, -1,  8,  7};
        tbl[2] = '{0,  0, -1,  0,  0};
        tbl[3] = '{21, 3, -1, 64, 35};
        tbl[4] = '{1,  2, -1,  4,  5};
        tbl[5] = '{2,  0,  3,  8,  7};
        tbl[6] = '{5,  1, -1, 20, 13};
        tbl[7] = '{2,  0, -1,  8,  7};

        nrst = 1'b0; start = 1'b0; num_words = '0; s_valid = 1'b0;
        s_data = '0; s_last = 1'b0; last_w = '0; err_exp = 1'b0;
        #3;
        chk("rst_fifo_en", fifo_en, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_weight", weight_in, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int j = 0; j < 8; j++) begin
            do_job(tbl[j].nwq, tbl[j].mode, tbl[j].bad_last, tbl[j].exp_beats, tbl[j].exp_stream);
        end

        // reset while loading column 2 abandons the job
        start = 1'b1; num_words = 5'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
            @(negedge clk);
        end
        #2 nrst = 1'b0;
        #1;
        chk("abort_fifo_en", fifo_en, 0);
        chk("abort_weight", weight_in, 0);
        chk("abort_ready", s_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_en", out_en, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        s_valid = 1'b0;
        last_w = '0; err_exp = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle_busy", busy, 0);
        end
        do_job(2, 0, -1, 8, 7);

        for (int j = 0; j < 6; j++) begin
            nwq = $urandom_range(0, 20);
            nwc = (nwq > DEPTH) ? DEPTH : nwq;
            do_job(nwq, $urandom_range(0, 3),
                   ($urandom % 3 == 0) ? $urandom_range(0, COL * nwc) : -1,
                   COL * nwc, (nwc == 0) ? 0 : COL - 1 + 2 * nwc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
